// File: rtl/vend_dispatch.sv
// vend_dispatch: vending-machine dispense controller.
// Collects coin credit, checks it against a selected product's price, runs the
// product motor for a fixed number of cycles, waits for the drop sensor, pays
// out change, and latches a jam fault if the product never drops.
// Optional feature: define VEND_RETRY_EN to retry the motor run once after
// the first drop-sensor timeout before declaring a fault.
// Ports:
//   CLK, RESET        clock (rising edge), synchronous active-high reset
//   COIN_VLD/COIN_VAL coin pulse and value
//   SEL_VLD/SEL/PRICE selection strobe, product index, price of that product
//   CANCEL            refund request (honoured only while holding credit)
//   SENSE             product-drop detector
//   MOTOR             one-hot motor drive
//   CREDIT            accumulated credit
//   CHANGE_VLD/CHANGE change or refund pulse and value
//   COIN_REJ          coin-rejected pulse
//   BUSY, FAULT       busy (check/run/wait/fault) and jam-fault flags
//   IND               state code
module vend_dispatch #(
  parameter int unsigned NPROD    = 4,
  parameter int unsigned CRED_W   = 4,
  parameter int unsigned RUN_CYC  = 5,
  parameter int unsigned WAIT_CYC = 6
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      COIN_VLD,
  input  logic [CRED_W-1:0]         COIN_VAL,
  input  logic                      SEL_VLD,
  input  logic [$clog2(NPROD)-1:0]  SEL,
  input  logic [CRED_W-1:0]         PRICE,
  input  logic                      CANCEL,
  input  logic                      SENSE,
  output logic [NPROD-1:0]          MOTOR,
  output logic [CRED_W-1:0]         CREDIT,
  output logic                      CHANGE_VLD,
  output logic [CRED_W-1:0]         CHANGE,
  output logic                      COIN_REJ,
  output logic                      BUSY,
  output logic                      FAULT,
  output logic [2:0]                IND
);

  localparam int unsigned SEL_W    = $clog2(NPROD);
  localparam int unsigned SEL_SPAN = 2 ** SEL_W;
  localparam int unsigned CNT_W    = 8;
  // One bit per encodable index; set only for indices that name a real channel.
  localparam logic [SEL_SPAN-1:0] SEL_MASK = SEL_SPAN'((64'd1 << NPROD) - 64'd1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CREDIT = 3'd1,
    S_CHECK  = 3'd2,
    S_RUN    = 3'd3,
    S_WAIT   = 3'd4,
    S_PAY    = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [CRED_W-1:0]  credit_q, credit_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [CRED_W-1:0]  price_q, price_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NPROD-1:0]   motor_d;
  logic               change_vld_d, coin_rej_d, busy_d, fault_d;
  logic [CRED_W-1:0]  change_d;
  logic [CRED_W:0]    sum;
`ifdef VEND_RETRY_EN
  logic               retry_q, retry_d;
`endif

  assign CREDIT = credit_q;
  assign IND    = state_q;

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    credit_d     = credit_q;
    sel_d        = sel_q;
    price_d      = price_q;
    cnt_d        = cnt_q;
    change_vld_d = 1'b0;
    change_d     = '0;
    coin_rej_d   = COIN_VLD;
`ifdef VEND_RETRY_EN
    retry_d      = retry_q;
`endif
    sum = {1'b0, credit_q} + {1'b0, COIN_VAL};

    case (state_q)
      S_IDLE, S_CREDIT: begin
        if (state_q == S_CREDIT && CANCEL) begin
          // Refund wins over a coincident selection; a coincident coin bounces.
          change_vld_d = 1'b1;
          change_d     = credit_q;
          credit_d     = '0;
          state_d      = S_IDLE;
        end else begin
          coin_rej_d = COIN_VLD && sum[CRED_W];
          if (COIN_VLD && !sum[CRED_W]) begin
            credit_d = sum[CRED_W-1:0];
            state_d  = S_CREDIT;
          end
          if (SEL_VLD && SEL_MASK[SEL]) begin
            sel_d   = SEL;
            price_d = PRICE;
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (credit_q >= price_q) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          state_d = (credit_q == '0) ? S_IDLE : S_CREDIT;
        end
      end
      S_RUN: begin
        if (SENSE) begin
          state_d = S_PAY;
        end else if (cnt_q == CNT_W'(RUN_CYC - 1)) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (SENSE) begin
          state_d = S_PAY;
        end else if (cnt_q == CNT_W'(WAIT_CYC - 1)) begin
          cnt_d = '0;
`ifdef VEND_RETRY_EN
          if (!retry_q) begin
            state_d = S_RUN;
            retry_d = 1'b1;
          end else begin
            state_d = S_FAULT;
          end
`else
          state_d = S_FAULT;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PAY:   state_d = S_IDLE;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase

    // PAY is only ever entered from RUN/WAIT, so this fires exactly once per vend.
    if (state_d == S_PAY) begin
      change_vld_d = 1'b1;
      change_d     = credit_q - price_q;
      credit_d     = '0;
`ifdef VEND_RETRY_EN
      retry_d      = 1'b0;
`endif
    end

    motor_d = (state_d == S_RUN) ? (NPROD'(1) << sel_d) : '0;
    busy_d  = (state_d == S_CHECK) || (state_d == S_RUN) ||
              (state_d == S_WAIT)  || (state_d == S_FAULT);
    fault_d = (state_d == S_FAULT);
  end

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      credit_q   <= '0;
      sel_q      <= '0;
      price_q    <= '0;
      cnt_q      <= '0;
      MOTOR      <= '0;
      CHANGE_VLD <= 1'b0;
      CHANGE     <= '0;
      COIN_REJ   <= 1'b0;
      BUSY       <= 1'b0;
      FAULT      <= 1'b0;
`ifdef VEND_RETRY_EN
      retry_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      sel_q      <= sel_d;
      price_q    <= price_d;
      cnt_q      <= cnt_d;
      MOTOR      <= motor_d;
      CHANGE_VLD <= change_vld_d;
      CHANGE     <= change_d;
      COIN_REJ   <= coin_rej_d;
      BUSY       <= busy_d;
      FAULT      <= fault_d;
`ifdef VEND_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

endmodule

// File: tb/tb_vend_dispatch.sv
// tb_vend_dispatch: directed scenarios plus randomized traffic for
// vend_dispatch, every cycle compared against a behavioural model.
module tb_vend_dispatch;

  localparam int NPROD    = 4;
  localparam int CRED_W   = 4;
  localparam int RUN_CYC  = 5;
  localparam int WAIT_CYC = 6;
  localparam int MAXC     = (1 << CRED_W) - 1;
`ifdef VEND_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic                     CLK = 1'b0;
  logic                     RESET = 1'b1;
  logic                     COIN_VLD = 1'b0;
  logic [CRED_W-1:0]        COIN_VAL = '0;
  logic                     SEL_VLD = 1'b0;
  logic [$clog2(NPROD)-1:0] SEL = '0;
  logic [CRED_W-1:0]        PRICE = '0;
  logic                     CANCEL = 1'b0;
  logic                     SENSE = 1'b0;
  logic [NPROD-1:0]         MOTOR;
  logic [CRED_W-1:0]        CREDIT;
  logic                     CHANGE_VLD;
  logic [CRED_W-1:0]        CHANGE;
  logic                     COIN_REJ;
  logic                     BUSY;
  logic                     FAULT;
  logic [2:0]               IND;

  vend_dispatch #(.NPROD(NPROD), .CRED_W(CRED_W), .RUN_CYC(RUN_CYC), .WAIT_CYC(WAIT_CYC)) dut (
    .CLK(CLK), .RESET(RESET), .COIN_VLD(COIN_VLD), .COIN_VAL(COIN_VAL),
    .SEL_VLD(SEL_VLD), .SEL(SEL), .PRICE(PRICE), .CANCEL(CANCEL), .SENSE(SENSE),
    .MOTOR(MOTOR), .CREDIT(CREDIT), .CHANGE_VLD(CHANGE_VLD), .CHANGE(CHANGE),
    .COIN_REJ(COIN_REJ), .BUSY(BUSY), .FAULT(FAULT), .IND(IND)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: phase numbers are the published state codes; the
  // motor/wait phases count remaining cycles down.
  int m_phase, m_credit, m_sel, m_price, m_left;
  bit m_retried, m_cv, m_rej;
  int m_change;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_pay();
    m_cv      = 1'b1;
    m_change  = m_credit - m_price;
    m_credit  = 0;
    m_retried = 1'b0;
    m_phase   = 5;
  endtask

  task automatic model(input bit rst, input bit cv, input int cval, input bit sv,
                       input int s, input int p, input bit can, input bit sen);
    int nxt;
    m_cv = 1'b0; m_change = 0; m_rej = 1'b0;
    if (rst) begin
      m_phase = 0; m_credit = 0; m_sel = 0; m_price = 0; m_left = 0; m_retried = 1'b0;
      return;
    end
    nxt = m_phase;
    if (m_phase <= 1) begin
      if (m_phase == 1 && can) begin
        m_cv = 1'b1; m_change = m_credit; m_credit = 0; nxt = 0; m_rej = cv;
      end else begin
        if (cv) begin
          if (m_credit + cval <= MAXC) begin m_credit += cval; nxt = 1; end
          else m_rej = 1'b1;
        end
        if (sv && s < NPROD) begin m_sel = s; m_price = p; nxt = 2; end
      end
      m_phase = nxt;
      return;
    end
    m_rej = cv;
    case (m_phase)
      2: begin
        if (m_credit >= m_price) begin m_phase = 3; m_left = RUN_CYC; end
        else m_phase = (m_credit == 0) ? 0 : 1;
      end
      3: begin
        if (sen) model_pay();
        else begin
          m_left--;
          if (m_left == 0) begin m_phase = 4; m_left = WAIT_CYC; end
        end
      end
      4: begin
        if (sen) model_pay();
        else begin
          m_left--;
          if (m_left == 0) begin
            if (RETRY && !m_retried) begin m_retried = 1'b1; m_phase = 3; m_left = RUN_CYC; end
            else m_phase = 6;
          end
        end
      end
      5: m_phase = 0;
      default: m_phase = 6;
    endcase
  endtask

  task automatic compare_all();
    check("IND",        32'(IND),        32'(m_phase));
    check("MOTOR",      32'(MOTOR),      (m_phase == 3) ? (32'd1 << m_sel) : 32'd0);
    check("CREDIT",     32'(CREDIT),     32'(m_credit));
    check("CHANGE_VLD", 32'(CHANGE_VLD), 32'(m_cv));
    check("CHANGE",     32'(CHANGE),     32'(m_change));
    check("COIN_REJ",   32'(COIN_REJ),   32'(m_rej));
    check("BUSY",       32'(BUSY),       32'(m_phase == 2 || m_phase == 3 || m_phase == 4 || m_phase == 6));
    check("FAULT",      32'(FAULT),      32'(m_phase == 6));
  endtask

  // Apply one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input bit rst, input bit cv, input int cval, input bit sv,
                      input int s, input int p, input bit can, input bit sen);
    RESET = rst; COIN_VLD = cv; COIN_VAL = CRED_W'(cval); SEL_VLD = sv;
    SEL = 2'(s); PRICE = CRED_W'(p); CANCEL = can; SENSE = sen;
    model(rst, cv, cval, sv, s, p, can, sen);
    @(posedge CLK);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int lat;

    // Reset state
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check("rst_ind", 32'(IND), 32'd0);
    check("rst_credit", 32'(CREDIT), 32'd0);

    // Normal vend with change of 1
    step(0, 1, 3, 0, 0, 0, 0, 0);
    step(0, 1, 2, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 4, 0, 0);
    check("vend_check", 32'(IND), 32'd2);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("vend_motor", 32'(MOTOR), 32'b0010);
    idle(RUN_CYC);
    check("vend_wait", 32'(IND), 32'd4);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    check("vend_cvld", 32'(CHANGE_VLD), 32'd1);
    check("vend_change", 32'(CHANGE), 32'd1);
    check("vend_credit0", 32'(CREDIT), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("vend_idle", 32'(IND), 32'd0);

    // Overflowing coin is rejected, then refund of 14
    step(0, 1, 7, 0, 0, 0, 0, 0);
    step(0, 1, 7, 0, 0, 0, 0, 0);
    step(0, 1, 3, 0, 0, 0, 0, 0);
    check("ovf_rej", 32'(COIN_REJ), 32'd1);
    check("ovf_credit", 32'(CREDIT), 32'd14);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    check("cancel_change", 32'(CHANGE), 32'd14);
    check("cancel_idle", 32'(IND), 32'd0);

    // Insufficient credit, then cancel outranks selection
    step(0, 1, 2, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2, 5, 0, 0);
    check("short_check", 32'(IND), 32'd2);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("short_back", 32'(IND), 32'd1);
    check("short_motor", 32'(MOTOR), 32'd0);
    step(0, 0, 0, 1, 2, 1, 1, 0);
    check("cansel_change", 32'(CHANGE), 32'd2);
    check("cansel_ind", 32'(IND), 32'd0);

    // Jam: sensor never fires
    step(0, 1, 5, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 3, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    lat = 0;
    while (FAULT !== 1'b1 && lat < 100) begin
      step(0, 0, 0, 0, 0, 0, 0, 0);
      lat++;
    end
    check("jam_latency", 32'(lat), RETRY ? 32'(2 * (RUN_CYC + WAIT_CYC)) : 32'(RUN_CYC + WAIT_CYC));
    step(0, 1, 1, 0, 0, 0, 1, 0);
    check("fault_rej", 32'(COIN_REJ), 32'd1);
    check("fault_credit", 32'(CREDIT), 32'd5);

    // Reset mid-run
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 4, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2, 3, 0, 0);
    idle(3);
    check("midrun_motor", 32'(MOTOR), 32'b0100);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check("midrun_rst_motor", 32'(MOTOR), 32'd0);
    check("midrun_rst_credit", 32'(CREDIT), 32'd0);
    check("midrun_rst_ind", 32'(IND), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 1,
           $urandom_range(0, 99) < 30, int'($urandom_range(0, MAXC)),
           $urandom_range(0, 99) < 15, int'($urandom_range(0, NPROD - 1)),
           int'($urandom_range(0, MAXC)),
           $urandom_range(0, 99) < 5,
           $urandom_range(0, 99) < 10);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
